// File: rtl/mem_req_arbiter.sv
// Shares one word-level memory port between fetch, load and store; one request in flight.
// Latency: grant 1 cycle after IDLE selection; done/ack 1 cycle after in_mem_done, then one bubble.
// Backpressure: requesters hold req until done/ack; rdy low freezes all state and suppresses pulses.
module mem_req_arbiter #(
    parameter int         ADDR_WIDTH   = 32,
    parameter int         DATA_WIDTH   = 32,
    parameter int         STARVE_LIMIT = 8,
    parameter logic [1:0] IO_SEL       = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_fetch_req,
    input  logic [ADDR_WIDTH-1:0] in_fetch_addr,
    output logic                  out_fetch_done,
    input  logic                  in_load_req,
    input  logic [ADDR_WIDTH-1:0] in_load_addr,
    input  logic [2:0]            in_load_size,
    input  logic                  in_load_signed,
    output logic                  out_load_done,
    input  logic                  in_store_req,
    input  logic [ADDR_WIDTH-1:0] in_store_addr,
    input  logic [2:0]            in_store_size,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    output logic                  out_store_ack,
    input  logic                  in_flush,
    output logic                  out_mem_req,
    output logic                  out_mem_rw,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [2:0]            out_mem_size,
    output logic                  out_mem_signed,
    output logic [DATA_WIDTH-1:0] out_mem_wdata,
    input  logic                  in_mem_done,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
    output logic [DATA_WIDTH-1:0] out_data
);
    localparam int            CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD, OWN_STORE} owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                grant;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fdone_q, fdone_d;
    logic                  ldone_q, ldone_d;
    logic                  sack_q, sack_d;
    logic                  fetch_ok, load_ok;

    // Selection, request launch, completion routing and flush cancellation.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        fdone_d  = 1'b0;
        ldone_d  = 1'b0;
        sack_d   = 1'b0;
        grant    = OWN_NONE;
        // A flush cancels the speculative readers; an IO load must not pass a pending store.
        fetch_ok = in_fetch_req && !in_flush;
        load_ok  = in_load_req && !in_flush &&
                   !((in_load_addr[17:16] == IO_SEL) && in_store_req);
        case (state_q)
            IDLE: begin
                if (fetch_ok && (cnt_q >= CNT_MAX)) grant = OWN_FETCH;
                else if (in_store_req)              grant = OWN_STORE;
                else if (load_ok)                   grant = OWN_LOAD;
                else if (fetch_ok)                  grant = OWN_FETCH;
                case (grant)
                    OWN_FETCH: begin
                        rw_d = 1'b0; addr_d = in_fetch_addr; size_d = 3'd4;
                        sgn_d = 1'b0; wdata_d = '0;
                    end
                    OWN_LOAD: begin
                        rw_d = 1'b0; addr_d = in_load_addr; size_d = in_load_size;
                        sgn_d = in_load_signed; wdata_d = '0;
                    end
                    OWN_STORE: begin
                        rw_d = 1'b1; addr_d = in_store_addr; size_d = in_store_size;
                        sgn_d = 1'b0; wdata_d = in_store_data;
                    end
                    default: ;
                endcase
                if (grant != OWN_NONE) begin
                    req_d   = 1'b1;
                    owner_d = grant;
                    state_d = BUSY;
                    if (grant == OWN_FETCH) begin
                        cnt_d = '0;
                    end else if (in_fetch_req && (cnt_q < CNT_MAX)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            BUSY: begin
                if (in_flush && (owner_q != OWN_STORE)) begin
                    // Cancelled read: never report it, drain it if still in flight.
                    if (in_mem_done) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (in_mem_done) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    case (owner_q)
                        OWN_FETCH: begin fdone_d = 1'b1; data_d = in_mem_rdata; end
                        OWN_LOAD:  begin ldone_d = 1'b1; data_d = in_mem_rdata; end
                        OWN_STORE: sack_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            DRAIN: begin
                if (in_mem_done) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; rdy gates every update and pulses only fire on ready cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
            fdone_q <= 1'b0;
            ldone_q <= 1'b0;
            sack_q  <= 1'b0;
        end else begin
            if (rdy) begin
                state_q <= state_d;
                owner_q <= owner_d;
                cnt_q   <= cnt_d;
                req_q   <= req_d;
                rw_q    <= rw_d;
                addr_q  <= addr_d;
                size_q  <= size_d;
                sgn_q   <= sgn_d;
                wdata_q <= wdata_d;
                data_q  <= data_d;
            end
            fdone_q <= rdy & fdone_d;
            ldone_q <= rdy & ldone_d;
            sack_q  <= rdy & sack_d;
        end
    end

    assign out_mem_req    = req_q;
    assign out_mem_rw     = rw_q;
    assign out_mem_addr   = addr_q;
    assign out_mem_size   = size_q;
    assign out_mem_signed = sgn_q;
    assign out_mem_wdata  = wdata_q;
    assign out_data       = data_q;
    assign out_fetch_done = fdone_q;
    assign out_load_done  = ldone_q;
    assign out_store_ack  = sack_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized and directed stimulus for mem_req_arbiter checked against a transaction-level model.
// Latency: model predicts registered outputs one edge ahead; outputs compared every falling edge.
// Backpressure: requesters hold until done/ack, a bench memory answers after 1-4 ready cycles.
module tb_mem_req_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        in_fetch_req, in_load_req, in_load_signed, in_store_req, in_flush, in_mem_done;
    logic [31:0] in_fetch_addr, in_load_addr, in_store_addr, in_store_data, in_mem_rdata;
    logic [2:0]  in_load_size, in_store_size;
    logic        out_fetch_done, out_load_done, out_store_ack;
    logic        out_mem_req, out_mem_rw, out_mem_signed;
    logic [31:0] out_mem_addr, out_mem_wdata, out_data;
    logic [2:0]  out_mem_size;

    always #5 clk = ~clk;

    mem_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(8), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_fetch_req(in_fetch_req), .in_fetch_addr(in_fetch_addr), .out_fetch_done(out_fetch_done),
        .in_load_req(in_load_req), .in_load_addr(in_load_addr), .in_load_size(in_load_size),
        .in_load_signed(in_load_signed), .out_load_done(out_load_done),
        .in_store_req(in_store_req), .in_store_addr(in_store_addr), .in_store_size(in_store_size),
        .in_store_data(in_store_data), .out_store_ack(out_store_ack),
        .in_flush(in_flush),
        .out_mem_req(out_mem_req), .out_mem_rw(out_mem_rw), .out_mem_addr(out_mem_addr),
        .out_mem_size(out_mem_size), .out_mem_signed(out_mem_signed), .out_mem_wdata(out_mem_wdata),
        .in_mem_done(in_mem_done), .in_mem_rdata(in_mem_rdata), .out_data(out_data)
    );

    // Transaction view: is something in flight, is its result thrown away, who asked for it.
    typedef struct packed {
        logic        busy;
        logic        discard;
        logic [1:0]  who;      // 1 fetch, 2 load, 3 store
        logic [7:0]  skip;     // non-fetch grants while fetch waited
        logic        req;
        logic        rw;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        sgn;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        fd;
        logic        ld;
        logic        sa;
    } model_t;

    model_t m, n;
    int  ncmp = 0;
    int  nbad = 0;
    bit  cmp_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        bit fe, le, cancel;
        int pick;
        n = m;
        n.fd = 1'b0; n.ld = 1'b0; n.sa = 1'b0;
        if (rst) begin n = '0; return; end
        if (!rdy) return;
        if (!m.busy) begin
            fe = in_fetch_req && !in_flush;
            le = in_load_req && !in_flush && !(in_load_addr[17:16] == 2'b11 && in_store_req);
            pick = 0;
            if (fe && m.skip >= 8) pick = 1;
            else if (in_store_req)  pick = 3;
            else if (le)            pick = 2;
            else if (fe)            pick = 1;
            if (pick != 0) begin
                n.busy = 1'b1; n.discard = 1'b0; n.who = 2'(pick); n.req = 1'b1;
                if (pick == 1) begin
                    n.rw = 1'b0; n.addr = in_fetch_addr; n.size = 3'd4; n.sgn = 1'b0; n.wdata = '0;
                    n.skip = 0;
                end else if (pick == 2) begin
                    n.rw = 1'b0; n.addr = in_load_addr; n.size = in_load_size;
                    n.sgn = in_load_signed; n.wdata = '0;
                end else begin
                    n.rw = 1'b1; n.addr = in_store_addr; n.size = in_store_size;
                    n.sgn = 1'b0; n.wdata = in_store_data;
                end
                if (pick != 1 && in_fetch_req && m.skip < 8) n.skip = m.skip + 8'd1;
            end
        end else begin
            cancel = m.discard || (in_flush && m.who != 2'd3);
            if (in_mem_done) begin
                n.busy = 1'b0; n.discard = 1'b0; n.req = 1'b0;
                if (!cancel) begin
                    if (m.who == 2'd1) begin n.fd = 1'b1; n.data = in_mem_rdata; end
                    else if (m.who == 2'd2) begin n.ld = 1'b1; n.data = in_mem_rdata; end
                    else n.sa = 1'b1;
                end
            end else if (cancel) begin
                n.discard = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        m = n;
        #1;
    endtask

    function automatic logic [2:0] rand_size();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? 3'd1 : (r == 1) ? 3'd2 : 3'd4;
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_req", out_mem_req, m.req);
            chk("mem_rw", out_mem_rw, m.rw);
            chk("mem_addr", out_mem_addr, m.addr);
            chk("mem_size", out_mem_size, m.size);
            chk("mem_signed", out_mem_signed, m.sgn);
            chk("mem_wdata", out_mem_wdata, m.wdata);
            chk("out_data", out_data, m.data);
            chk("fetch_done", out_fetch_done, m.fd);
            chk("load_done", out_load_done, m.ld);
            chk("store_ack", out_store_ack, m.sa);
        end
    end

    initial begin
        bit pending, flush_prev;
        int lat;
        rst = 1; rdy = 1;
        in_fetch_req = 0; in_load_req = 0; in_store_req = 0; in_flush = 0; in_mem_done = 0;
        in_fetch_addr = 0; in_load_addr = 0; in_store_addr = 0; in_store_data = 0; in_mem_rdata = 0;
        in_load_size = 0; in_load_signed = 0; in_store_size = 0;
        m = '0; n = '0;
        cmp_en = 1;
        repeat (2) tick();
        chk("rst_req", out_mem_req, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ack", out_store_ack, 0);
        rst = 0;
        tick();

        // Store beats load; load follows two cycles after the store completes.
        in_store_req = 1; in_store_addr = 32'h100; in_store_data = 32'hDEADBEEF; in_store_size = 3'd4;
        in_load_req = 1; in_load_addr = 32'h200; in_load_size = 3'd4; in_load_signed = 0;
        tick();
        chk("t1_rw", out_mem_rw, 1);
        chk("t1_addr", out_mem_addr, 32'h100);
        chk("t1_wdata", out_mem_wdata, 32'hDEADBEEF);
        in_mem_done = 1; tick(); in_mem_done = 0;
        chk("t1_ack", out_store_ack, 1);
        in_store_req = 0;
        tick();
        chk("t1_load_req", out_mem_req, 1);
        chk("t1_load_addr", out_mem_addr, 32'h200);
        in_mem_done = 1; in_mem_rdata = 32'h12345678; tick(); in_mem_done = 0;
        chk("t1_ldone", out_load_done, 1);
        chk("t1_data", out_data, 32'h12345678);
        in_load_req = 0;

        // IO load waits behind a store.
        in_load_req = 1; in_load_addr = 32'h30000;
        in_store_req = 1; in_store_addr = 32'h40; in_store_data = 32'h11;
        tick();
        chk("t3_rw", out_mem_rw, 1);
        chk("t3_addr", out_mem_addr, 32'h40);
        in_mem_done = 1; tick(); in_mem_done = 0;
        chk("t3_ack", out_store_ack, 1);
        in_store_req = 0;
        tick();
        chk("t3_load_addr", out_mem_addr, 32'h30000);
        in_mem_done = 1; in_mem_rdata = 32'h0BADF00D; tick(); in_mem_done = 0;
        chk("t3_data", out_data, 32'h0BADF00D);
        in_load_req = 0;

        // Flushed fetch drains silently.
        in_fetch_req = 1; in_fetch_addr = 32'h1000;
        tick();
        chk("t4_size", out_mem_size, 4);
        in_flush = 1; in_fetch_req = 0;
        tick();
        in_flush = 0;
        chk("t4_drain_req", out_mem_req, 1);
        tick(); tick();
        in_mem_done = 1; in_mem_rdata = 32'hFFFF0000; tick(); in_mem_done = 0;
        chk("t4_req_drop", out_mem_req, 0);
        chk("t4_no_done", out_fetch_done, 0);
        chk("t4_data_hold", out_data, 32'h0BADF00D);

        // Store completes through a flush; readers ignored while flush is high.
        in_store_req = 1; in_store_addr = 32'h44; in_store_size = 3'd2; in_store_data = 32'hA5A5;
        tick();
        in_flush = 1; in_fetch_req = 1; in_fetch_addr = 32'h2000; in_load_req = 1; in_load_addr = 32'h300;
        in_mem_done = 1; tick(); in_mem_done = 0;
        chk("t5_ack", out_store_ack, 1);
        in_store_req = 0;
        tick();
        chk("t5_no_grant", out_mem_req, 0);
        in_flush = 0; in_fetch_req = 0; in_load_req = 0;
        tick();

        // Asynchronous reset mid-transaction.
        in_load_req = 1; in_load_addr = 32'h500;
        tick();
        chk("t6_busy", out_mem_req, 1);
        #2 rst = 1; m = '0;
        #1;
        chk("t6_rst_req", out_mem_req, 0);
        chk("t6_rst_addr", out_mem_addr, 0);
        chk("t6_rst_data", out_data, 0);
        in_load_req = 0;
        tick();
        rst = 0;
        tick();

        // Fetch anti-starvation: ninth grant goes to the waiting fetch.
        in_fetch_req = 1; in_fetch_addr = 32'h8000; in_load_addr = 32'h200;
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0 || i == 8) in_store_req = 1; else in_load_req = 1;
            tick();
            if (i < 8) chk("t2_nonfetch_addr_ne", (out_mem_addr == 32'h8000), 0);
            else begin
                chk("t2_fetch_addr", out_mem_addr, 32'h8000);
                chk("t2_fetch_size", out_mem_size, 4);
                chk("t2_cnt_zero", dut.cnt_q, 0);
            end
            in_mem_done = 1; in_mem_rdata = $urandom; tick(); in_mem_done = 0;
            if (out_store_ack) in_store_req = 0;
            if (out_load_done) in_load_req = 0;
            if (out_fetch_done) in_fetch_req = 0;
        end
        in_store_req = 0; in_load_req = 0; in_fetch_req = 0;
        tick();

        // rdy low freezes a busy request.
        in_fetch_req = 1; in_fetch_addr = 32'h9000;
        tick();
        rdy = 0; in_mem_done = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t7_hold_req", out_mem_req, 1);
            chk("t7_hold_addr", out_mem_addr, 32'h9000);
            chk("t7_no_pulse", out_fetch_done, 0);
        end
        rdy = 1; in_mem_rdata = 32'hCAFEF00D;
        tick(); in_mem_done = 0;
        chk("t7_done", out_fetch_done, 1);
        chk("t7_data", out_data, 32'hCAFEF00D);
        in_fetch_req = 0;
        tick();

        // Random traffic with flushes, stalls and variable memory latency.
        pending = 0; flush_prev = 0; lat = 0;
        for (int c = 0; c < 4000; c++) begin
            if (out_fetch_done || flush_prev) in_fetch_req = 0;
            if (out_load_done || flush_prev) in_load_req = 0;
            if (out_store_ack) in_store_req = 0;
            rdy = ($urandom_range(0, 15) != 0);
            in_flush = rdy && ($urandom_range(0, 24) == 0);
            flush_prev = in_flush;
            if (!in_fetch_req && $urandom_range(0, 3) == 0) begin
                in_fetch_req = 1; in_fetch_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!in_load_req && $urandom_range(0, 3) == 0) begin
                in_load_req = 1; in_load_addr = $urandom;
                if ($urandom_range(0, 2) == 0) in_load_addr[17:16] = 2'b11;
                in_load_size = rand_size(); in_load_signed = 1'($urandom_range(0, 1));
            end
            if (!in_store_req && $urandom_range(0, 4) == 0) begin
                in_store_req = 1; in_store_addr = $urandom; in_store_data = $urandom;
                in_store_size = rand_size();
            end
            in_mem_done = 0;
            if (rdy && out_mem_req) begin
                if (!pending) begin pending = 1; lat = $urandom_range(0, 3); end
                if (lat == 0) begin
                    in_mem_done = 1; in_mem_rdata = $urandom; pending = 0;
                end else begin
                    lat--;
                end
            end
            tick();
        end
        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", ncmp, nbad);
        $finish;
    end
endmodule
